// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the two buses of the instruction-memory loader:
//   - the incoming byte stream (valid/ready handshake)
//   - the outgoing instruction-memory write port
//
//   Signals
//     in_valid  stream byte valid
//     in_data   stream byte
//     in_ready  loader accepts a byte this cycle
//     wr_en     one-cycle instruction-memory write strobe
//     wr_addr   byte address of the word being written (word_index*4)
//     wr_data   assembled instruction word
//
//   Modports
//     master  the loader: sinks the stream and drives the memory write port
//     slave   the environment: sources the stream and observes the writes
// ----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         wr_en;
   logic [N-1:0] wr_addr;
   logic [N-1:0] wr_data;

   modport master (
      input  in_valid,
      input  in_data,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      output in_valid,
      output in_data,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction-memory interface. Accepts a byte stream of
//   the form CNT_HI, CNT_LO (big-endian 16-bit word count) followed by
//   count*4 bytes, MSB first within each word. Each group of four bytes is
//   assembled into one N-bit instruction and written to instruction memory at
//   byte address word_index*4. The processor is held (cpu_hold=1) until the
//   whole program has been loaded.
//
//   Ports
//     clk       system clock, rising edge
//     rst       asynchronous reset, active-low
//     start     one-cycle pulse: abort any load in progress and re-arm
//     bus       imem_loader_if.master: byte stream in, memory write port out
//     cpu_hold  1 = keep processor stalled (every state except DONE)
//     done      load completed successfully (level)
//     err       header word count exceeded DEPTH (level)
//
//   Parameters
//     N      instruction width; must be 32 (four bytes per word)
//     DEPTH  number of instruction-memory words; legal counts are 0..DEPTH
// ----------------------------------------------------------------------------
module imem_loader #(
   parameter int N     = 32,
   parameter int DEPTH = 101
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   imem_loader_if.master  bus,
   output logic           cpu_hold,
   output logic           done,
   output logic           err
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   typedef enum logic [2:0] {
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t       state;
   state_t       state_nxt;

   logic [7:0]   cnt_hi;
   logic [15:0]  count;
   logic [15:0]  word_index;
   logic [1:0]   byte_cnt;
   logic [N-1:0] wr_addr_q;
   logic [N-1:0] wr_data_q;

   logic         in_ready_c;
   logic         wr_en_c;
   logic         xfer;
   logic [15:0]  cnt_in;

   // Full word count as it stands once the low header byte is on the bus.
   assign cnt_in = {cnt_hi, bus.in_data};
   assign xfer   = bus.in_valid & in_ready_c;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_CNT_HI;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and handshake/strobe decode
   // -------------------------------------------------------------------------
   // NOTE: every variable written here gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      wr_en_c    = 1'b0;

      case (state)
         S_CNT_HI: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = S_CNT_LO;
         end
         S_CNT_LO: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               if (cnt_in == 16'd0)         state_nxt = S_DONE;
               else if (cnt_in > DEPTH_W)   state_nxt = S_ERR;
               else                         state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            in_ready_c = 1'b1;
            if (bus.in_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            wr_en_c = 1'b1;
            if (word_index + 16'd1 == count) state_nxt = S_DONE;
            else                             state_nxt = S_DATA;
         end
         S_DONE:  state_nxt = S_DONE;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_CNT_HI;
      endcase

      // start overrides everything, including a byte offered this cycle.
      if (start) state_nxt = S_CNT_HI;
   end

   // -------------------------------------------------------------------------
   // Datapath: header capture, word assembly, write address, word counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_hi     <= '0;
         count      <= '0;
         word_index <= '0;
         byte_cnt   <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else if (start) begin
         // Any partially assembled word is abandoned; no write follows.
         word_index <= '0;
         byte_cnt   <= '0;
      end else begin
         case (state)
            S_CNT_HI: begin
               if (xfer) cnt_hi <= bus.in_data;
            end
            S_CNT_LO: begin
               if (xfer) begin
                  count      <= cnt_in;
                  word_index <= '0;
                  byte_cnt   <= '0;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  wr_data_q <= {wr_data_q[N-9:0], bus.in_data};
                  byte_cnt  <= byte_cnt + 2'd1;
                  // Address is latched with the last byte so it is already
                  // stable during the single WRITE cycle.
                  if (byte_cnt == 2'd3) wr_addr_q <= N'({word_index, 2'b00});
               end
            end
            S_WRITE: begin
               word_index <= word_index + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.wr_en    = wr_en_c;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

   assign cpu_hold = (state != S_DONE);
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);

endmodule
